arm_decode_alu_cond: RTL and testbench

- ID/EX-stage datapath slice of the 5-stage ARM-subset pipeline.
- Combinational instruction decoder feeding the ID/EX register, and 32-bit ALU for the EX stage.
- Clocked program-status (flag) register.
- Condition evaluator producing branch-taken and branch-with-link-taken for the ID-stage instruction; these drive the PC-select mux and the IF/ID flush.

---
 rtl/arm_decode_alu_cond.sv | 252 +++++++++++++++++++++++++
 tb/tb_arm_decode_alu_cond.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_decode_alu_cond.sv
// ---------------------------------------------------------------------------
// arm_decode_alu_cond
//
// ID/EX datapath slice of a 5-stage ARM-subset pipeline.
//   * Combinational decoder for the ID-stage instruction word.
//     Its outputs feed the ID/EX pipeline register.
//   * 32-bit EX-stage ALU with {N,Z,C,V} flag generation.
//   * Clocked program-status register (PSR) holding {N,Z,C,V}.
//   * Condition evaluator for the ID-stage branch. It drives the PC-select
//     mux and the IF/ID flush.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   instruction       ID-stage instruction word
//   id_*              decoded control fields for the ID-stage instruction
//   ex_alu_op         EX-stage ALU operation
//   ex_a, ex_b        EX-stage operands (ex_b is the shifter output)
//   ex_s_instr        the EX-stage instruction writes the flags
//   alu_out, alu_cc   ALU result and its {N,Z,C,V}
//   psr_cc            registered {N,Z,C,V}
//   br_taken          ID-stage B/BL whose condition holds
//   bl_taken          ID-stage BL whose condition holds
// ---------------------------------------------------------------------------
module arm_decode_alu_cond (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [3:0]  id_alu_op,
    output logic        id_s_bit,
    output logic        id_load_instr,
    output logic        id_rf_enable,
    output logic        id_b_instr,
    output logic        id_bl_instr,
    output logic        id_enable_instr,
    output logic        id_size,
    output logic        id_rw,
    output logic [1:0]  id_shift_am,
    output logic [1:0]  id_sop_count,
    input  logic [3:0]  ex_alu_op,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_s_instr,
    output logic [31:0] alu_out,
    output logic [3:0]  alu_cc,
    output logic [3:0]  psr_cc,
    output logic        br_taken,
    output logic        bl_taken
);

    // Flag bit positions within the {N,Z,C,V} nibbles
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    logic [3:0]  r_psr;

    logic [3:0]  w_opcode;
    logic        w_rn_used;

    logic        w_arith;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_result;

    logic [3:0]  w_flags;
    logic        w_cond_true;

    // Offsets, register numbers and immediates are consumed further down
    // the pipe, not in this slice.
    logic        w_unused_bits;
    assign w_unused_bits = ^instruction[19:0];

    // -----------------------------------------------------------------------
    // Instruction decoder
    // -----------------------------------------------------------------------
    assign w_opcode  = instruction[24:21];
    // MOV (1101) and MVN (1111) take no Rn operand.
    assign w_rn_used = !((w_opcode == 4'b1101) || (w_opcode == 4'b1111));

    always_comb begin
        id_alu_op       = 4'b0000;
        id_s_bit        = 1'b0;
        id_load_instr   = 1'b0;
        id_rf_enable    = 1'b0;
        id_b_instr      = 1'b0;
        id_bl_instr     = 1'b0;
        id_enable_instr = 1'b0;
        id_size         = 1'b0;
        id_rw           = 1'b0;
        id_shift_am     = 2'b00;
        id_sop_count    = 2'b00;

        if (instruction == 32'h0000_0000) begin
            // An all-zero word is a pipeline bubble (NOP).
            // All defaults stand.
        end else if (instruction[27:26] == 2'b00) begin
            // Data processing
            id_s_bit    = instruction[20];
            id_shift_am = instruction[25] ? 2'b00 : 2'b01;
            case (w_opcode)
                4'b0000: id_alu_op = 4'b0110;  // AND
                4'b0001: id_alu_op = 4'b1000;  // EOR
                4'b0010: id_alu_op = 4'b0010;  // SUB
                4'b0011: id_alu_op = 4'b0100;  // RSB
                4'b0100: id_alu_op = 4'b0000;  // ADD
                4'b0101: id_alu_op = 4'b0001;  // ADC
                4'b0110: id_alu_op = 4'b0011;  // SBC
                4'b0111: id_alu_op = 4'b0101;  // RSC
                4'b1000: id_alu_op = 4'b0110;  // TST
                4'b1001: id_alu_op = 4'b1000;  // TEQ
                4'b1010: id_alu_op = 4'b0010;  // CMP
                4'b1011: id_alu_op = 4'b0000;  // CMN
                4'b1100: id_alu_op = 4'b0111;  // ORR
                4'b1101: id_alu_op = 4'b1010;  // MOV
                4'b1110: id_alu_op = 4'b1100;  // BIC
                default: id_alu_op = 4'b1011;  // MVN
            endcase
            // The compare/test group (opcodes 10xx) sets flags only.
            id_rf_enable = (w_opcode[3:2] != 2'b10);
            id_sop_count = {1'b0, w_rn_used} + {1'b0, !instruction[25]};
        end else if (instruction[27:26] == 2'b01) begin
            // Single load/store
            id_enable_instr = 1'b1;
            id_size         = instruction[22];
            // U bit selects add or subtract of the offset.
            id_alu_op       = instruction[23] ? 4'b0000 : 4'b0010;
            id_shift_am     = instruction[25] ? 2'b11 : 2'b10;
            if (instruction[20]) begin
                id_load_instr = 1'b1;
                id_rw         = 1'b0;
                id_rf_enable  = 1'b1;
            end else begin
                id_rw         = 1'b1;
                id_rf_enable  = 1'b0;
            end
            // Rn always; Rm for register offset; Rd read as store data.
            id_sop_count = 2'd1 + {1'b0, instruction[25]}
                         + {1'b0, !instruction[20]};
        end else if (instruction[27:25] == 3'b101) begin
            // B / BL: the ALU adds the offset to the PC.
            id_b_instr  = 1'b1;
            id_bl_instr = instruction[24];
            id_alu_op   = 4'b0000;
        end
    end

    // -----------------------------------------------------------------------
    // ALU
    // Every add/subtract form is x + y + cin on a 33-bit adder.
    // Subtraction is x + ~y + 1, so carry-out set means "no borrow".
    // -----------------------------------------------------------------------
    always_comb begin
        w_arith = 1'b1;
        w_x     = ex_a;
        w_y     = ex_b;
        w_cin   = 1'b0;
        case (ex_alu_op)
            4'b0000: begin w_x = ex_a; w_y = ex_b;  w_cin = 1'b0;           end
            4'b0001: begin w_x = ex_a; w_y = ex_b;  w_cin = r_psr[FLAG_C];  end
            4'b0010: begin w_x = ex_a; w_y = ~ex_b; w_cin = 1'b1;           end
            4'b0011: begin w_x = ex_a; w_y = ~ex_b; w_cin = r_psr[FLAG_C];  end
            4'b0100: begin w_x = ex_b; w_y = ~ex_a; w_cin = 1'b1;           end
            4'b0101: begin w_x = ex_b; w_y = ~ex_a; w_cin = r_psr[FLAG_C];  end
            default: w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};

    always_comb begin
        w_result = 32'd0;
        case (ex_alu_op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0101: w_result = w_sum[31:0];
            4'b0110: w_result = ex_a & ex_b;
            4'b0111: w_result = ex_a | ex_b;
            4'b1000: w_result = ex_a ^ ex_b;
            4'b1001: w_result = ex_a;
            4'b1010: w_result = ex_b;
            4'b1011: w_result = ~ex_b;
            4'b1100: w_result = ex_a & ~ex_b;
            default: w_result = 32'd0;
        endcase
    end

    assign alu_out = w_result;

    always_comb begin
        alu_cc[FLAG_N] = w_result[31];
        alu_cc[FLAG_Z] = (w_result == 32'd0);
        if (w_arith) begin
            alu_cc[FLAG_C] = w_sum[32];
            // Overflow: both addends share a sign that the sum does not.
            alu_cc[FLAG_V] = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
        end else begin
            // Logic/move ops leave C and V untouched.
            alu_cc[FLAG_C] = r_psr[FLAG_C];
            alu_cc[FLAG_V] = r_psr[FLAG_V];
        end
    end

    // -----------------------------------------------------------------------
    // Program status register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psr <= 4'b0000;
        end else if (ex_s_instr) begin
            r_psr <= alu_cc;
        end
    end

    assign psr_cc = r_psr;

    // -----------------------------------------------------------------------
    // Condition evaluation for the ID-stage branch.
    // A flag-setting instruction in EX is one cycle ahead of the PSR.
    // Its flags are forwarded so the branch sees them now.
    // -----------------------------------------------------------------------
    assign w_flags = ex_s_instr ? alu_cc : r_psr;

    always_comb begin
        w_cond_true = 1'b0;
        case (instruction[31:28])
            4'b0000: w_cond_true =  w_flags[FLAG_Z];                              // EQ
            4'b0001: w_cond_true = !w_flags[FLAG_Z];                              // NE
            4'b0010: w_cond_true =  w_flags[FLAG_C];                              // CS
            4'b0011: w_cond_true = !w_flags[FLAG_C];                              // CC
            4'b0100: w_cond_true =  w_flags[FLAG_N];                              // MI
            4'b0101: w_cond_true = !w_flags[FLAG_N];                              // PL
            4'b0110: w_cond_true =  w_flags[FLAG_V];                              // VS
            4'b0111: w_cond_true = !w_flags[FLAG_V];                              // VC
            4'b1000: w_cond_true =  w_flags[FLAG_C] && !w_flags[FLAG_Z];          // HI
            4'b1001: w_cond_true = !w_flags[FLAG_C] ||  w_flags[FLAG_Z];          // LS
            4'b1010: w_cond_true = (w_flags[FLAG_N] == w_flags[FLAG_V]);          // GE
            4'b1011: w_cond_true = (w_flags[FLAG_N] != w_flags[FLAG_V]);          // LT
            4'b1100: w_cond_true = !w_flags[FLAG_Z] &&
                                   (w_flags[FLAG_N] == w_flags[FLAG_V]);          // GT
            4'b1101: w_cond_true =  w_flags[FLAG_Z] ||
                                   (w_flags[FLAG_N] != w_flags[FLAG_V]);          // LE
            4'b1110: w_cond_true = 1'b1;                                          // AL
            default: w_cond_true = 1'b0;                                          // NV
        endcase
    end

    assign br_taken = id_b_instr  & w_cond_true;
    assign bl_taken = id_bl_instr & w_cond_true;

endmodule

// File: tb/tb_arm_decode_alu_cond.sv
// ---------------------------------------------------------------------------
// Self-checking bench for arm_decode_alu_cond.
// Directed cases come first, followed by randomized transactions.
// All expectations come from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_arm_decode_alu_cond;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  id_alu_op;
    logic        id_s_bit;
    logic        id_load_instr;
    logic        id_rf_enable;
    logic        id_b_instr;
    logic        id_bl_instr;
    logic        id_enable_instr;
    logic        id_size;
    logic        id_rw;
    logic [1:0]  id_shift_am;
    logic [1:0]  id_sop_count;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        ex_s_instr;
    logic [31:0] alu_out;
    logic [3:0]  alu_cc;
    logic [3:0]  psr_cc;
    logic        br_taken;
    logic        bl_taken;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    logic [3:0] m_psr;   // model of the flag register {N,Z,C,V}

    arm_decode_alu_cond dut (
        .clk             (clk),
        .reset           (reset),
        .instruction     (instruction),
        .id_alu_op       (id_alu_op),
        .id_s_bit        (id_s_bit),
        .id_load_instr   (id_load_instr),
        .id_rf_enable    (id_rf_enable),
        .id_b_instr      (id_b_instr),
        .id_bl_instr     (id_bl_instr),
        .id_enable_instr (id_enable_instr),
        .id_size         (id_size),
        .id_rw           (id_rw),
        .id_shift_am     (id_shift_am),
        .id_sop_count    (id_sop_count),
        .ex_alu_op       (ex_alu_op),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_s_instr      (ex_s_instr),
        .alu_out         (alu_out),
        .alu_cc          (alu_cc),
        .psr_cc          (psr_cc),
        .br_taken        (br_taken),
        .bl_taken        (bl_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ALU reference using wide signed/unsigned integer arithmetic.
    // Subtraction is done as subtraction, so carry means "no borrow".
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] psr,
                           output logic [31:0] out, output logic [3:0] cc);
        longint ua, ub, sa, sb, u, s, ci;
        logic   arith;
        ua = a;  ub = b;
        sa = $signed(a);  sb = $signed(b);
        ci = psr[1] ? 1 : 0;
        arith = 1'b1;
        u = 0;  s = 0;
        out = 32'd0;
        case (op)
            4'd0: begin u = ua + ub;                         s = sa + sb;          end
            4'd1: begin u = ua + ub + ci;                    s = sa + sb + ci;     end
            4'd2: begin u = ua + 64'h1_0000_0000 - ub;       s = sa - sb;          end
            4'd3: begin u = ua + 64'hFFFF_FFFF - ub + ci;    s = sa - sb - 1 + ci; end
            4'd4: begin u = ub + 64'h1_0000_0000 - ua;       s = sb - sa;          end
            4'd5: begin u = ub + 64'hFFFF_FFFF - ua + ci;    s = sb - sa - 1 + ci; end
            default: arith = 1'b0;
        endcase
        if (arith) out = u[31:0];
        else case (op)
            4'd6:  out = a & b;
            4'd7:  out = a | b;
            4'd8:  out = a ^ b;
            4'd9:  out = a;
            4'd10: out = b;
            4'd11: out = ~b;
            4'd12: out = a & ~b;
            default: out = 32'd0;
        endcase
        cc[3] = out[31];
        cc[2] = (out == 32'd0);
        if (arith) begin
            cc[1] = (u >= 64'h1_0000_0000);
            cc[0] = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end else begin
            cc[1] = psr[1];
            cc[0] = psr[0];
        end
    endtask

    // Decode reference.
    // Packed as {alu_op, s, load, rf, b, bl, en, size, rw, shift_am, sop}.
    function automatic logic [15:0] ref_decode(input logic [31:0] ins);
        logic [3:0] dp_map [16];
        logic [3:0] op, alu;
        logic s, ld, rf, b, bl, en, sz, rw;
        logic [1:0] sh;
        int sop;
        dp_map = '{4'h6, 4'h8, 4'h2, 4'h4, 4'h0, 4'h1, 4'h3, 4'h5,
                   4'h6, 4'h8, 4'h2, 4'h0, 4'h7, 4'hA, 4'hC, 4'hB};
        alu = 0; s = 0; ld = 0; rf = 0; b = 0; bl = 0;
        en = 0; sz = 0; rw = 0; sh = 0; sop = 0;
        op = ins[24:21];
        if (ins == 32'd0) begin
            // NOP
        end else if (ins[27:26] == 2'b00) begin
            alu = dp_map[op];
            s   = ins[20];
            sh  = ins[25] ? 2'b00 : 2'b01;
            rf  = !(op >= 4'd8 && op <= 4'd11);
            sop = ((op == 4'd13 || op == 4'd15) ? 0 : 1) + (ins[25] ? 0 : 1);
        end else if (ins[27:26] == 2'b01) begin
            en  = 1;
            sz  = ins[22];
            alu = ins[23] ? 4'h0 : 4'h2;
            sh  = ins[25] ? 2'b11 : 2'b10;
            ld  = ins[20];
            rw  = !ins[20];
            rf  = ins[20];
            sop = 1 + (ins[25] ? 1 : 0) + (ins[20] ? 0 : 1);
        end else if (ins[27:25] == 3'b101) begin
            b  = 1;
            bl = ins[24];
        end
        return {alu, s, ld, rf, b, bl, en, sz, rw, sh, sop[1:0]};
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One full transaction: drive on the falling edge and check the
    // combinational outputs. Then cross a rising edge and check the PSR.
    task automatic run_txn(input logic [31:0] ins, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        logic [31:0] e_out;
        logic [3:0]  e_cc, e_flags;
        logic [15:0] e_dec;
        logic        e_cond;
        @(negedge clk);
        instruction = ins;  ex_alu_op = op;  ex_a = a;  ex_b = b;  ex_s_instr = s;
        #1;
        ref_alu(op, a, b, m_psr, e_out, e_cc);
        e_dec   = ref_decode(ins);
        e_flags = s ? e_cc : m_psr;
        e_cond  = ref_cond(ins[31:28], e_flags);
        check_value("alu_out", alu_out, e_out);
        check_value("alu_cc",  {28'd0, alu_cc}, {28'd0, e_cc});
        check_value("decode",
                    {16'd0, id_alu_op, id_s_bit, id_load_instr, id_rf_enable,
                     id_b_instr, id_bl_instr, id_enable_instr, id_size, id_rw,
                     id_shift_am, id_sop_count},
                    {16'd0, e_dec});
        check_value("br_taken", {31'd0, br_taken}, {31'd0, e_dec[8] & e_cond});
        check_value("bl_taken", {31'd0, bl_taken}, {31'd0, e_dec[7] & e_cond});
        @(posedge clk);
        #1;
        if (s) m_psr = e_cc;
        check_value("psr_cc", {28'd0, psr_cc}, {28'd0, m_psr});
        $display("txn %0d ins=%h op=%h a=%h b=%h s=%b out=%h cc=%b psr=%b br=%b bl=%b",
                 n_txn, ins, op, a, b, s, alu_out, alu_cc, psr_cc, br_taken, bl_taken);
        n_txn++;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    function automatic logic [31:0] pick_instr();
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1, 2:    return {c, 2'b00, 26'($urandom)};
            3:       return {c, 2'b01, 26'($urandom)};
            4:       return {c, 3'b101, 25'($urandom)};
            default: return {c, ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b110, 25'($urandom)};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        instruction = 32'd0;  ex_alu_op = 4'd0;  ex_a = 32'd0;  ex_b = 32'd0;
        ex_s_instr = 1'b0;
        m_psr = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_psr", {28'd0, psr_cc}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Add wrapping to zero: Z and C set, result stored in the PSR
        run_txn(32'd0, 4'h0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check_value("add_wrap_psr", {28'd0, psr_cc}, 32'h6);
        // Subtract with borrow, then signed overflow
        run_txn(32'd0, 4'h2, 32'h5, 32'h7, 1'b0);
        check_value("sub_borrow_out", alu_out, 32'hFFFF_FFFE);
        run_txn(32'd0, 4'h2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_value("sub_ovf_v", {31'd0, alu_cc[0]}, 32'd1);

        // Decode examples: MOV, LDR, STRB
        run_txn(32'hE3A0_1005, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("mov_alu_op", {28'd0, id_alu_op}, 32'hA);
        check_value("mov_sop",    {30'd0, id_sop_count}, 32'd0);
        run_txn(32'hE591_2000, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("ldr_shift",  {30'd0, id_shift_am}, 32'd2);
        check_value("ldr_load",   {31'd0, id_load_instr}, 32'd1);
        run_txn(32'hE5C1_2004, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("strb_rw_size", {30'd0, id_rw, id_size}, 32'd3);

        // Branches: PSR Z=1 (from the first add), BEQ taken
        run_txn(32'h0A00_0002, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("beq_z1", {31'd0, br_taken}, 32'd1);
        // Clear Z via a flag-setting move of B=1
        run_txn(32'd0, 4'hA, 32'd0, 32'h1, 1'b1);
        run_txn(32'h0A00_0002, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("beq_z0", {31'd0, br_taken}, 32'd0);
        run_txn(32'hEB00_0001, 4'h0, 32'd0, 32'd0, 1'b0);
        check_value("bl_al", {30'd0, br_taken, bl_taken}, 32'd3);

        // Randomized transactions
        for (int i = 0; i < 400; i++) begin
            run_txn(pick_instr(), 4'($urandom_range(0, 15)), pick_operand(),
                    pick_operand(), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with a non-zero PSR (Z, C and V set)
        run_txn(32'd0, 4'h0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        check_value("pre_reset_psr", {28'd0, psr_cc}, 32'h7);
        @(negedge clk);
        ex_s_instr = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_value("async_reset_psr", {28'd0, psr_cc}, 32'd0);
        reset = 1'b0;
        m_psr = 4'b0000;
        run_txn(32'h0A00_0000, 4'h9, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
